// File: rtl/serializer_input.sv
// Parallel-in/serial-out converter: loads a WIDTH-bit word on start_i and shifts it out one bit per clock.
// Optional macro SERIALIZER_INPUT_PARITY_EN appends an even-parity bit to every frame.
module serializer_input #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             data_o,
  output logic             ena_o
);

`ifdef SERIALIZER_INPUT_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_shift, w_shift_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic             r_data, w_data_next;
  logic             r_ena, w_ena_next;

  logic             w_first_bit;
  logic             w_shift_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_load_shift;
  logic [WIDTH-1:0] w_adv_shift;

  // The shift register always holds the bits still to come, aligned so the next one sits at the output end.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first_bit  = data_i[WIDTH-1];
      assign w_load_shift = {data_i[WIDTH-2:0], 1'b0};
      assign w_shift_bit  = r_shift[WIDTH-1];
      assign w_adv_shift  = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_first_bit  = data_i[0];
      assign w_load_shift = {1'b0, data_i[WIDTH-1:1]};
      assign w_shift_bit  = r_shift[0];
      assign w_adv_shift  = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIALIZER_INPUT_PARITY_EN
  logic r_parity, w_parity_next;
  assign w_next_bit = (r_cnt == CW'(WIDTH - 1)) ? r_parity : w_shift_bit;
`else
  assign w_next_bit = w_shift_bit;
`endif

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    w_data_next  = 1'b0;
    w_ena_next   = 1'b0;
`ifdef SERIALIZER_INPUT_PARITY_EN
    w_parity_next = r_parity;
`endif
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_next = SHIFT;
          w_shift_next = w_load_shift;
          w_cnt_next   = '0;
          w_data_next  = w_first_bit;
          w_ena_next   = 1'b1;
`ifdef SERIALIZER_INPUT_PARITY_EN
          w_parity_next = ^data_i;
`endif
        end
      end
      SHIFT: begin
        if (r_cnt != LAST_IDX) begin
          w_shift_next = w_adv_shift;
          w_cnt_next   = r_cnt + CW'(1);
          w_data_next  = w_next_bit;
          w_ena_next   = 1'b1;
        end else if (start_i) begin
          // Last bit on the line: a new start chains the next frame with no gap.
          w_shift_next = w_load_shift;
          w_cnt_next   = '0;
          w_data_next  = w_first_bit;
          w_ena_next   = 1'b1;
`ifdef SERIALIZER_INPUT_PARITY_EN
          w_parity_next = ^data_i;
`endif
        end else begin
          w_state_next = IDLE;
          w_shift_next = '0;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_shift_next = '0;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_data  <= 1'b0;
      r_ena   <= 1'b0;
`ifdef SERIALIZER_INPUT_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
      r_data  <= w_data_next;
      r_ena   <= w_ena_next;
`ifdef SERIALIZER_INPUT_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  assign data_o = r_data;
  assign ena_o  = r_ena;

endmodule

// File: tb/tb_serializer_input.sv
// Scoreboard bench for serializer_input: drives MSB-first and LSB-first instances with shared
// directed and random stimulus and checks every cycle of both serial outputs.
module tb_serializer_input;

  localparam int W = 8;
`ifdef SERIALIZER_INPUT_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] data_i;
  logic         data_msb, ena_msb;
  logic         data_lsb, ena_lsb;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  logic q_m[$];
  logic q_l[$];

  always #5 clk = ~clk;

  serializer_input #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .data_i  (data_i),
    .data_o  (data_msb),
    .ena_o   (ena_msb)
  );

  serializer_input #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .data_i  (data_i),
    .data_o  (data_lsb),
    .ena_o   (ena_lsb)
  );

  function automatic void check(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b, expected %b", nm, $time, act, exp);
    end
  endfunction

  // Reference model: a frame is a list of bits; a start is taken only when nothing is left to send
  // after the bit currently on the line.
  always @(posedge clk) begin
    if (!rst_i) begin
      q_m.delete();
      q_l.delete();
      mon_en = 1'b1;
    end else if (start_i && q_m.size() == 0) begin
      for (int k = 0; k < W; k++) begin
        q_m.push_back(data_i[W-1-k]);
        q_l.push_back(data_i[k]);
      end
`ifdef SERIALIZER_INPUT_PARITY_EN
      q_m.push_back(^data_i);
      q_l.push_back(^data_i);
`endif
      $display("frame accepted @%0t: word=%h", $time, data_i);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (q_m.size() > 0) begin
        check("msb_ena", ena_msb, 1'b1);
        check("msb_bit", data_msb, q_m.pop_front());
      end else begin
        check("msb_ena_idle", ena_msb, 1'b0);
        check("msb_data_idle", data_msb, 1'b0);
      end
      if (q_l.size() > 0) begin
        check("lsb_ena", ena_lsb, 1'b1);
        check("lsb_bit", data_lsb, q_l.pop_front());
      end else begin
        check("lsb_ena_idle", ena_lsb, 1'b0);
        check("lsb_data_idle", data_lsb, 1'b0);
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic [W-1:0] d);
    rst_i   = r;
    start_i = s;
    data_i  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, W'($urandom));
  endtask

  initial begin
    rst_i   = 1'b0;
    start_i = 1'b1;
    data_i  = 8'hFF;
    // Reset dominates start; nothing may begin after release without a fresh start.
    repeat (3) drive(1'b0, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, 8'hFF);
    idle(4);
    // Single frames.
    drive(1'b1, 1'b1, 8'hA5);
    idle(FL + 2);
    drive(1'b1, 1'b1, 8'h01);
    idle(FL + 2);
    // Back-to-back: second start lands on the last-bit cycle.
    drive(1'b1, 1'b1, 8'hF0);
    idle(FL - 1);
    drive(1'b1, 1'b1, 8'h0F);
    idle(FL + 2);
    // Mid-frame start is ignored.
    drive(1'b1, 1'b1, 8'hC3);
    idle(3);
    drive(1'b1, 1'b1, 8'h3C);
    idle(FL + 2);
    // Reset mid-frame aborts it.
    drive(1'b1, 1'b1, 8'hAA);
    idle(4);
    drive(1'b0, 1'b0, 8'h00);
    idle(FL + 2);
    drive(1'b1, 1'b1, 8'h07);
    idle(FL + 2);
    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 2) == 0, W'($urandom));
    idle(FL + 2);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serializer_input.md
Name: serializer_input

Overview:
- Parallel-in/serial-out converter: loads a WIDTH-bit word on a start strobe, then shifts it out one bit per clock on data_o.
- ena_o qualifies each valid serial bit.
- Sits between a parallel word producer and a bit-serial link or downstream shifter.
- Single clock domain, registered outputs.

Parameters:
- WIDTH, 8, number of bits in data_i and number of serial bits per frame (>=2).
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.

Ports:
- clk_i  input  1  system clock, rising-edge active.
- rst_i  input  1  reset; synchronous, active-low (0 = reset).
- start_i  input  1  start strobe; sampled each rising edge.
- data_i  input  WIDTH  parallel word; captured on the edge that accepts start_i.
- data_o  output  1  serial data bit, registered.
- ena_o  output  1  high while data_o carries a valid frame bit, registered.

Behaviour:
- Reset: rst_i sampled low on a rising edge forces:
  - FSM to IDLE
  - shift register and bit counter to 0
  - data_o=0, ena_o=0
- Reset has priority over start_i.
- Reset mid-frame aborts the frame; no residual bits are emitted after reset release.
- FSM states: IDLE, SHIFT.
- IDLE:
  - ena_o=0, data_o=0.
  - start_i=1 at an edge: capture data_i, counter=0, go to SHIFT.
  - On that same edge, data_o <= first bit (data_i[WIDTH-1] if MSB_FIRST else data_i[0]) and ena_o <= 1.
- Latency: first bit is visible one cycle after the start_i edge, i.e. in the cycle following the one where start_i was high.
- SHIFT:
  - Each edge presents the next bit; ena_o stays 1 for exactly WIDTH consecutive cycles per frame.
  - Bit order per MSB_FIRST; data_o on cycle k (k=0..WIDTH-1) = word bit (WIDTH-1-k) or k.
- Frame end:
  - On the edge after the last bit is presented, return to IDLE with ena_o=0, data_o=0.
  - Exception: start_i=1 on that edge starts the next frame.
- Back-to-back:
  - start_i high during the cycle the last bit is presented is accepted.
  - The new word's first bit follows immediately; ena_o stays high continuously (2*WIDTH cycles for two frames, no gap).
- start_i while SHIFT and not on the last bit: ignored. The current frame is not disturbed, and data_i is not re-captured.
- data_i is only sampled on accepting edges; changes at other times have no effect.
- Counter width: clog2(WIDTH+1) bits; no wrap-around beyond WIDTH.
- data_o is forced 0 whenever ena_o=0.

Optional Feature:
- Macro: SERIALIZER_INPUT_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra even-parity bit (XOR of the captured word) is emitted on data_o.
  - ena_o high for WIDTH+1 cycles per frame.
  - The back-to-back accept window moves to the parity-bit cycle.
  - Mid-frame start_i is still ignored.
- Not defined: frames are exactly WIDTH bits; no parity logic is present.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles with start_i=1, data_i=8'hFF -> data_o=0 and ena_o=0 throughout; no frame starts after release until start_i is re-asserted.
- Single frame, WIDTH=8, MSB_FIRST=1: start_i pulse with data_i=8'hA5 -> starting the next cycle, data_o=1,0,1,0,0,1,0,1 with ena_o=1 for exactly 8 cycles, then ena_o=0, data_o=0.
- LSB first, MSB_FIRST=0: data_i=8'h01 -> data_o=1,0,0,0,0,0,0,0 with ena_o high for 8 cycles.
- Back-to-back: 8'hF0, then start_i with 8'h0F in the last-bit cycle -> 16 continuous ena_o cycles, data_o=1111000000001111.
- Ignored start: start_i with 8'h3C on bit 3 of an 8'hC3 frame -> the 8'hC3 frame completes unchanged (11000011); ena_o drops afterward and 8'h3C is never sent.
- Reset mid-frame: rst_i=0 at bit 4 of 8'hAA -> ena_o=0, data_o=0 on the next cycle; remaining bits are never emitted.
- Parity build (macro defined): 8'h07 -> 11100000 followed by parity bit 1; ena_o high for 9 cycles.
